// File: rtl/rv32_writeback.sv
// RV32 writeback stage: result select, register-file port arbitration between the
// pipeline and a late-result FIFO, WB+1 forwarding copy, optional instret (RV32_WB_INSTRET_EN).
module rv32_writeback #(
  parameter int LATE_FIFO_DEPTH = 2,
  parameter int INSTRET_W       = 64
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 reg_write_i,
  input  logic [2:0]           result_source_i,
  input  logic [31:0]          alu_result_i,
  input  logic [31:0]          read_data_i,
  input  logic [31:0]          instr_i,
  input  logic [31:0]          pc_next_i,
  input  logic [31:0]          fpu_result_i,
  input  logic                 late_valid_i,
  input  logic [4:0]           late_rd_i,
  input  logic [31:0]          late_data_i,
  output logic                 late_ready_o,
  output logic                 rf_we_o,
  output logic [4:0]           rf_waddr_o,
  output logic [31:0]          rf_wdata_o,
  output logic                 fwd_valid_o,
  output logic [4:0]           fwd_rd_o,
  output logic [31:0]          fwd_data_o,
  output logic [31:0]          pending_mask_o,
  output logic [INSTRET_W-1:0] instret_o
);

  localparam int PW = (LATE_FIFO_DEPTH > 1) ? $clog2(LATE_FIFO_DEPTH) : 1;

  logic [31:0] pipe_result;
  logic [4:0]  pipe_rd;
  logic        retire, pipe_we;

  logic [4:0]                 fifo_rd   [LATE_FIFO_DEPTH];
  logic [31:0]                fifo_data [LATE_FIFO_DEPTH];
  logic [LATE_FIFO_DEPTH-1:0] fifo_vld;
  logic [PW-1:0]              wr_ptr, rd_ptr;
  logic                       full, empty, pop, push, bypass;

  always_comb begin
    unique case (result_source_i)
      3'b001:  pipe_result = read_data_i;
      3'b010:  pipe_result = pc_next_i;
      3'b011:  pipe_result = fpu_result_i;
      default: pipe_result = alu_result_i;
    endcase
  end

  // A non-zero rd already implies a non-bubble instruction; retire is folded in for clarity.
  assign retire  = |instr_i;
  assign pipe_rd = instr_i[11:7];
  assign pipe_we = reg_write_i && retire && (pipe_rd != 5'd0);

  assign full         = &fifo_vld;
  assign empty        = ~|fifo_vld;
  assign late_ready_o = !full;

  assign pop    = !pipe_we && !empty;
  assign bypass = !pipe_we && empty && late_valid_i && (late_rd_i != 5'd0);
  assign push   = late_valid_i && !full && (late_rd_i != 5'd0) && !bypass;

  always_comb begin
    rf_we_o    = 1'b0;
    rf_waddr_o = 5'd0;
    rf_wdata_o = 32'd0;
    if (pipe_we) begin
      rf_we_o    = 1'b1;
      rf_waddr_o = pipe_rd;
      rf_wdata_o = pipe_result;
    end else if (!empty) begin
      rf_we_o    = 1'b1;
      rf_waddr_o = fifo_rd[rd_ptr];
      rf_wdata_o = fifo_data[rd_ptr];
    end else if (bypass) begin
      rf_we_o    = 1'b1;
      rf_waddr_o = late_rd_i;
      rf_wdata_o = late_data_i;
    end
  end

  always_comb begin
    pending_mask_o = 32'd0;
    for (int i = 0; i < LATE_FIFO_DEPTH; i++)
      if (fifo_vld[i]) pending_mask_o[fifo_rd[i]] = 1'b1;
  end

  // Occupancy lives in the valid bits so reset clears the mask immediately.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      fifo_vld <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
    end else begin
      if (pop) begin
        fifo_vld[rd_ptr] <= 1'b0;
        rd_ptr           <= rd_ptr + PW'(1);
      end
      if (push) begin
        fifo_vld[wr_ptr] <= 1'b1;
        wr_ptr           <= wr_ptr + PW'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      fifo_rd[wr_ptr]   <= late_rd_i;
      fifo_data[wr_ptr] <= late_data_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      fwd_valid_o <= 1'b0;
      fwd_rd_o    <= 5'd0;
      fwd_data_o  <= 32'd0;
    end else begin
      fwd_valid_o <= rf_we_o;
      fwd_rd_o    <= rf_waddr_o;
      fwd_data_o  <= rf_wdata_o;
    end
  end

`ifdef RV32_WB_INSTRET_EN
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)       instret_o <= '0;
    else if (retire) instret_o <= instret_o + INSTRET_W'(1);
  end
`else
  assign instret_o = '0;
`endif

  // A pipeline write to a register with a queued late result would be overwritten out of order.
  same_rd_hazard: assert property (@(posedge clk_i) disable iff (rst_i)
    !(pipe_we && pending_mask_o[pipe_rd]));

endmodule

// File: tb/tb_rv32_writeback.sv
// Self-checking bench for rv32_writeback: directed plan steps plus random traffic
// against a queue-based reference model.
module tb_rv32_writeback;
  localparam int D  = 2;
  localparam int IW = 64;

  logic          clk_i = 1'b0, rst_i;
  logic          reg_write_i;
  logic [2:0]    result_source_i;
  logic [31:0]   alu_result_i, read_data_i, instr_i, pc_next_i, fpu_result_i;
  logic          late_valid_i;
  logic [4:0]    late_rd_i;
  logic [31:0]   late_data_i;
  logic          late_ready_o, rf_we_o, fwd_valid_o;
  logic [4:0]    rf_waddr_o, fwd_rd_o;
  logic [31:0]   rf_wdata_o, fwd_data_o, pending_mask_o;
  logic [IW-1:0] instret_o;

  rv32_writeback #(.LATE_FIFO_DEPTH(D), .INSTRET_W(IW)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .reg_write_i(reg_write_i), .result_source_i(result_source_i),
    .alu_result_i(alu_result_i), .read_data_i(read_data_i), .instr_i(instr_i),
    .pc_next_i(pc_next_i), .fpu_result_i(fpu_result_i), .late_valid_i(late_valid_i),
    .late_rd_i(late_rd_i), .late_data_i(late_data_i), .late_ready_o(late_ready_o),
    .rf_we_o(rf_we_o), .rf_waddr_o(rf_waddr_o), .rf_wdata_o(rf_wdata_o),
    .fwd_valid_o(fwd_valid_o), .fwd_rd_o(fwd_rd_o), .fwd_data_o(fwd_data_o),
    .pending_mask_o(pending_mask_o), .instret_o(instret_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct { logic [4:0] rd; logic [31:0] d; } ent_t;
  ent_t          q[$];
  logic          m_fv;
  logic [4:0]    m_frd;
  logic [31:0]   m_fd;
  logic [IW-1:0] m_ir;
  int            nvec = 0, nerr = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model_mask();
    logic [31:0] m = 32'd0;
    foreach (q[i]) m[q[i].rd] = 1'b1;
    return m;
  endfunction

  function automatic logic [31:0] model_result();
    case (result_source_i)
      3'd1:    return read_data_i;
      3'd2:    return pc_next_i;
      3'd3:    return fpu_result_i;
      default: return alu_result_i;
    endcase
  endfunction

  function automatic logic [IW-1:0] exp_instret();
`ifdef RV32_WB_INSTRET_EN
    return m_ir;
`else
    return '0;
`endif
  endfunction

  task automatic model_reset();
    q.delete();
    m_fv = 1'b0; m_frd = 5'd0; m_fd = 32'd0; m_ir = '0;
  endtask

  task automatic setin(input logic rw, input logic [2:0] src, input logic [4:0] rd,
                       input logic [31:0] res, input logic lv, input logic [4:0] lrd,
                       input logic [31:0] ld);
    reg_write_i = rw; result_source_i = src;
    instr_i = {20'h00000, rd, 7'h33};
    alu_result_i = res; read_data_i = ~res; pc_next_i = res + 32'd4; fpu_result_i = res ^ 32'h5a5a5a5a;
    late_valid_i = lv; late_rd_i = lrd; late_data_i = ld;
  endtask

  task automatic idle();
    setin(1'b0, 3'd0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    instr_i = 32'd0;
  endtask

  // One clock: compare all outputs with the model, then advance the model across the edge.
  task automatic step();
    logic pw, ewe, byp, rdy;
    logic [4:0] prd, ea;
    logic [31:0] ed;
    #1;
    prd = instr_i[11:7];
    pw  = reg_write_i && (prd != 5'd0);
    byp = 1'b0; ewe = 1'b0; ea = 5'd0; ed = 32'd0;
    if (pw) begin
      ewe = 1'b1; ea = prd; ed = model_result();
    end else if (q.size() > 0) begin
      ewe = 1'b1; ea = q[0].rd; ed = q[0].d;
    end else if (late_valid_i && late_rd_i != 5'd0) begin
      ewe = 1'b1; ea = late_rd_i; ed = late_data_i; byp = 1'b1;
    end
    rdy = (q.size() < D);
    chk("rf_we", 64'(rf_we_o), 64'(ewe));
    chk("rf_waddr", 64'(rf_waddr_o), 64'(ea));
    chk("rf_wdata", 64'(rf_wdata_o), 64'(ed));
    chk("late_ready", 64'(late_ready_o), 64'(rdy));
    chk("pending_mask", 64'(pending_mask_o), 64'(model_mask()));
    chk("fwd_valid", 64'(fwd_valid_o), 64'(m_fv));
    chk("fwd_rd", 64'(fwd_rd_o), 64'(m_frd));
    chk("fwd_data", 64'(fwd_data_o), 64'(m_fd));
    chk("instret", 64'(instret_o), 64'(exp_instret()));
    @(posedge clk_i);
    if (!pw && q.size() > 0) q.delete(0);
    if (late_valid_i && rdy && late_rd_i != 5'd0 && !byp) q.push_back('{rd: late_rd_i, d: late_data_i});
    m_fv = ewe; m_frd = ea; m_fd = ed;
    if (instr_i != 32'd0) m_ir = m_ir + IW'(1);
    @(negedge clk_i);
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    model_reset();
    @(negedge clk_i);
    rst_i = 1'b0;
  endtask

  initial begin
    logic [31:0] tmp;
    logic [4:0]  rd;
    logic        rw;
    rst_i = 1'b1;
    idle();
    model_reset();
    #3;
    chk("rst_late_ready", 64'(late_ready_o), 64'd1);
    chk("rst_mask", 64'(pending_mask_o), 64'd0);
    chk("rst_fwd_valid", 64'(fwd_valid_o), 64'd0);
    chk("rst_instret", 64'(instret_o), 64'd0);
    chk("rst_rf_we", 64'(rf_we_o), 64'd0);
    @(negedge clk_i);
    rst_i = 1'b0;

    // Mux select and x0 suppression
    setin(1'b1, 3'b010, 5'd5, 32'h100, 1'b0, 5'd0, 32'd0);
    #1;
    chk("mux_we", 64'(rf_we_o), 64'd1);
    chk("mux_addr", 64'(rf_waddr_o), 64'd5);
    chk("mux_link", 64'(rf_wdata_o), 64'h104);
    step();
    setin(1'b1, 3'b010, 5'd0, 32'h100, 1'b0, 5'd0, 32'd0);
    #1;
    chk("x0_we", 64'(rf_we_o), 64'd0);
    step();
    for (int s = 0; s < 8; s++) begin
      setin(1'b1, 3'(s), 5'(s + 1), 32'h1000 * 32'(s + 1), 1'b0, 5'd0, 32'd0);
      step();
    end

    // Bypass of a late result when the port is free
    setin(1'b0, 3'd0, 5'd0, 32'd0, 1'b1, 5'd7, 32'hDEAD);
    #1;
    chk("byp_addr", 64'(rf_waddr_o), 64'd7);
    chk("byp_data", 64'(rf_wdata_o), 64'hDEAD);
    step();
    idle();
    #1;
    chk("byp_mask", 64'(pending_mask_o), 64'd0);
    step();

    // Pipeline/late conflict queues the late result
    setin(1'b1, 3'd0, 5'd3, 32'hAA, 1'b1, 5'd9, 32'h55);
    #1;
    chk("cfl_addr", 64'(rf_waddr_o), 64'd3);
    step();
    idle();
    #1;
    chk("cfl_mask", 64'(pending_mask_o), 64'h200);
    chk("cfl_drain_addr", 64'(rf_waddr_o), 64'd9);
    chk("cfl_drain_data", 64'(rf_wdata_o), 64'h55);
    step();
    #1;
    chk("cfl_mask_clr", 64'(pending_mask_o), 64'd0);
    step();

    // Fill the FIFO under continuous pipeline writes, then drain in order
    for (int k = 0; k < 3; k++) begin
      setin(1'b1, 3'd0, 5'(10 + k), 32'h700 + 32'(k), 1'b1, 5'(20 + k), 32'hB00 + 32'(k));
      if (k == 2) begin
        #1;
        chk("full_ready", 64'(late_ready_o), 64'd0);
      end
      step();
    end
    idle();
    #1;
    chk("drain0_addr", 64'(rf_waddr_o), 64'd20);
    step();
    #1;
    chk("drain1_addr", 64'(rf_waddr_o), 64'd21);
    step();
    step();

    // Forwarding copy
    setin(1'b1, 3'd0, 5'd4, 32'h1234, 1'b0, 5'd0, 32'd0);
    step();
    idle();
    #1;
    chk("fwd_v", 64'(fwd_valid_o), 64'd1);
    chk("fwd_r", 64'(fwd_rd_o), 64'd4);
    chk("fwd_d", 64'(fwd_data_o), 64'h1234);
    step();

    // Retire count: 10 instructions and 3 bubbles after reset
    do_reset();
    for (int k = 0; k < 13; k++) begin
      idle();
      if (k % 4 != 3) instr_i = 32'h00000013 + 32'(k << 12);
      step();
    end
    #1;
`ifdef RV32_WB_INSTRET_EN
    chk("instret10", 64'(instret_o), 64'd10);
`else
    chk("instret10", 64'(instret_o), 64'd0);
`endif

    // Random traffic
    for (int n = 0; n < 400; n++) begin
      rw = 1'($urandom_range(0, 1));
      rd = 5'($urandom_range(0, 31));
      while (model_mask()[rd]) rd = 5'($urandom_range(0, 31));
      tmp = $urandom;
      setin(rw, 3'($urandom_range(0, 7)), rd, $urandom, 1'($urandom_range(0, 1)),
            5'($urandom_range(0, 31)), $urandom);
      instr_i = ($urandom_range(0, 4) == 0) ? 32'd0 : {tmp[31:12], rd, tmp[6:0]};
      step();
    end

    // Asynchronous reset with two queued entries
    do_reset();
    setin(1'b1, 3'd0, 5'd1, 32'h11, 1'b1, 5'd2, 32'h22);
    step();
    setin(1'b1, 3'd0, 5'd3, 32'h33, 1'b1, 5'd4, 32'h44);
    step();
    idle();
    #1;
    chk("pre_rst_mask", 64'(pending_mask_o), 64'h14);
    #1;
    rst_i = 1'b1;
    #1;
    chk("arst_ready", 64'(late_ready_o), 64'd1);
    chk("arst_mask", 64'(pending_mask_o), 64'd0);
    chk("arst_fwd_v", 64'(fwd_valid_o), 64'd0);
    chk("arst_fwd_r", 64'(fwd_rd_o), 64'd0);
    chk("arst_fwd_d", 64'(fwd_data_o), 64'd0);
    chk("arst_instret", 64'(instret_o), 64'd0);
    model_reset();
    @(negedge clk_i);
    rst_i = 1'b0;
    for (int k = 0; k < 3; k++) step();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule

// File: doc/rv32_writeback.md
Name: rv32_writeback

Overview:
- Final pipeline stage; consumes the memory-to-writeback register outputs and drives the integer register-file write port.
- Selects the result by result source.
- Merges results from a late multi-cycle unit (divider) through a small FIFO. Pipeline writes always have priority.
- Provides a registered WB+1 forwarding copy, a pending-rd mask for the hazard unit, and an optional instret counter.

Parameters:
LATE_FIFO_DEPTH, 2, late-result FIFO entries; power of two, >= 2
INSTRET_W, 64, width of retired-instruction counter

Ports:
clk_i  input  1  clock
rst_i  input  1  asynchronous reset, active-high
reg_write_i  input  1  pipeline register-write request
result_source_i  input  3  result select
alu_result_i  input  32  ALU result
read_data_i  input  32  aligned load data
instr_i  input  32  instruction; 32'h0 = bubble
pc_next_i  input  32  PC+4 (link value)
fpu_result_i  input  32  FPU integer-side result
late_valid_i  input  1  late unit result valid
late_rd_i  input  5  late result destination
late_data_i  input  32  late result data
late_ready_o  output  1  FIFO can accept a late result
rf_we_o  output  1  register-file write enable
rf_waddr_o  output  5  register-file write address
rf_wdata_o  output  32  register-file write data
fwd_valid_o  output  1  previous-cycle write valid (registered)
fwd_rd_o  output  5  previous-cycle write address
fwd_data_o  output  32  previous-cycle write data
pending_mask_o  output  32  bit n set = late result for xn queued
instret_o  output  INSTRET_W  retired-instruction count

Behaviour:
- Clock and reset: single clock clk_i. rst_i is asynchronous, active-high.
- Result mux (combinational):
  - 000 -> alu_result_i
  - 001 -> read_data_i
  - 010 -> pc_next_i
  - 011 -> fpu_result_i
  - 1xx -> alu_result_i (reserved encodings)
- Pipeline slot: pipe_we = reg_write_i && instr_i[11:7] != 0. Writes to x0 are suppressed.
- Port arbitration, each cycle (combinational onto rf_*):
  - If pipe_we: write the pipeline result to instr_i[11:7].
  - Else, if FIFO non-empty: pop the head and write it.
  - Else, if late_valid_i and late_rd_i != 0: write the late data directly (bypass, no enqueue).
  - Else: rf_we_o = 0, rf_waddr_o = 0, rf_wdata_o = 0.
- Enqueue:
  - Accept when late_valid_i && late_ready_o && late_rd_i != 0, unless the late result was bypassed that cycle.
  - late_rd_i == 0 is accepted and dropped.
- FIFO flow control:
  - late_ready_o = !full, from registered state. A full FIFO never accepts, even on a popping cycle.
  - Push and pop in the same cycle are allowed when not full; count is unchanged.
  - Pointers wrap modulo LATE_FIFO_DEPTH.
- pending_mask_o: OR of the one-hot rd of every valid FIFO entry (registered state).
  - The hazard unit stalls issue of instructions whose rd is in the mask.
  - The block does not reorder writes; same-rd conflict is an upstream obligation, flagged by a simulation assertion.
- Forwarding registers: on every clock, fwd_valid_o/fwd_rd_o/fwd_data_o <= rf_we_o/rf_waddr_o/rf_wdata_o. One-cycle latency.
- instret_o: increments by 1 each cycle instr_i != 32'h0. Wraps to 0 at all-ones.
- Reset values:
  - late_ready_o = 1; pending_mask_o = 0; FIFO empty.
  - fwd_* = 0; instret_o = 0.
  - rf_* follow the combinational rules (0 when inputs idle).
- Reset mid-operation: queued late results are discarded. The late unit is reset by the same rst_i.

Optional Feature:
- Macro: RV32_WB_INSTRET_EN.
- Defined: the INSTRET_W counter is implemented as above.
- Undefined: no counter flops; instret_o tied to 0.

Test Plan:
- Mux and x0 suppression: instr rd=5, result_source=010, pc_next=32'h104, reg_write=1 -> rf_we=1, waddr=5, wdata=32'h104. Same with rd=0 -> rf_we=0.
- Bypass: pipeline idle, late_valid=1, late_rd=7, data=32'hDEAD -> same-cycle write x7=32'hDEAD. FIFO stays empty; pending_mask=0.
- Conflict: pipeline writes x3 while late_valid rd=9 data=0x55 -> x3 written, late entry queued, pending_mask=32'h200. Next idle cycle -> x9=0x55 written, mask=0.
- Full: 2 late results during 3 cycles of continuous pipeline writes -> late_ready_o=0 after the second enqueue. A third late_valid is not accepted. Drain order is FIFO.
- Forwarding and instret: write x4=32'h1234 -> next cycle fwd_valid=1, fwd_rd=4, fwd_data=32'h1234. 10 non-zero instrs plus 3 bubbles -> instret_o=10 (macro on), 0 (macro off).
- Async reset with 2 entries queued: assert rst_i between clock edges -> immediately late_ready=1, pending_mask=0, fwd_*=0, instret=0.
